wbstream_slave: RTL and testbench

- Pipelined Wishbone slave endpoint: the responder-side peer of the DMA master.
- Wishbone writes to the data address push words into a TX FIFO, which drains to a valid/ready output stream.
- Wishbone reads from the data address pop words from an RX FIFO, which fills from a valid/ready input stream.
- FIFO-level interrupts feed the DMA controller's device-trigger inputs. Back-pressure is signalled through Wishbone stall, so a non-incrementing DMA transfer can move whole blocks without software polling.

---
 rtl/wbstream_slave.sv | 117 +++++++++++
 tb/tb_wbstream_slave.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wbstream_slave.sv
// Pipelined Wishbone slave bridging a data port to TX/RX stream FIFOs.
// Addr 0 pushes to TX / pops from RX; addr 1 is control (flush, threshold) and status (fills).
module wbstream_slave #(
  parameter int unsigned DW     = 32,
  parameter int unsigned LGFLEN = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic          i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  input  logic [DW-1:0] i_rx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic [DW-1:0] o_tx_data,
  output logic          o_rx_int,
  output logic          o_tx_int
);

  localparam int unsigned Depth = 1 << LGFLEN;

  logic [DW-1:0]     tx_mem [Depth];
  logic [DW-1:0]     rx_mem [Depth];
  logic [LGFLEN-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [LGFLEN:0]   tx_fill_q, rx_fill_q, rx_thresh_q;
  logic              ack_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic accept, tx_push, tx_pop, rx_push, rx_pop;
  logic ctl_wr, tx_flush, rx_flush;

  // Fill never exceeds Depth, so the MSB alone marks a full FIFO.
  assign tx_full  = tx_fill_q[LGFLEN];
  assign rx_full  = rx_fill_q[LGFLEN];
  assign tx_empty = (tx_fill_q == '0);
  assign rx_empty = (rx_fill_q == '0);

  assign o_wb_stall = i_wb_stb && !i_wb_addr && (i_wb_we ? tx_full : rx_empty);
  assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;

  assign tx_push  = accept && i_wb_we && !i_wb_addr;
  assign rx_pop   = accept && !i_wb_we && !i_wb_addr;
  assign ctl_wr   = accept && i_wb_we && i_wb_addr;
  assign tx_flush = ctl_wr && i_wb_data[30];
  assign rx_flush = ctl_wr && i_wb_data[31];

  assign o_tx_valid = !tx_empty;
  assign o_tx_data  = tx_mem[tx_rd_q];
  assign tx_pop     = o_tx_valid && i_tx_ready;

  assign o_rx_ready = !rx_full;
  assign rx_push    = i_rx_valid && o_rx_ready;

  // An abandoned cycle must not see the ack still in flight.
  assign o_wb_ack = ack_q && i_wb_cyc;

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= i_wb_data;
  end

  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || tx_flush) begin
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_fill_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (tx_push && !tx_pop)      tx_fill_q <= tx_fill_q + 1'b1;
      else if (!tx_push && tx_pop) tx_fill_q <= tx_fill_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || rx_flush) begin
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_fill_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      if (rx_push && !rx_pop)      rx_fill_q <= rx_fill_q + 1'b1;
      else if (!rx_push && rx_pop) rx_fill_q <= rx_fill_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_thresh_q <= '0;
      ack_q       <= 1'b0;
      o_wb_data   <= '0;
      o_rx_int    <= 1'b0;
      o_tx_int    <= 1'b1;
    end else begin
      ack_q    <= accept;
      o_rx_int <= (rx_thresh_q != '0) && (rx_fill_q >= rx_thresh_q);
      o_tx_int <= tx_empty;
      if (ctl_wr) rx_thresh_q <= i_wb_data[LGFLEN:0];
      if (accept && !i_wb_we) begin
        if (i_wb_addr) o_wb_data <= DW'({16'(rx_fill_q), 16'(tx_fill_q)});
        else           o_wb_data <= rx_mem[rx_rd_q];
      end
    end
  end

endmodule

// File: tb/tb_wbstream_slave.sv
// Directed plus random bench for wbstream_slave, checked against a queue-based FIFO model.
module tb_wbstream_slave;
  localparam int DW     = 32;
  localparam int LGFLEN = 2;
  localparam int DEPTH  = 1 << LGFLEN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
  logic [DW-1:0] wdat = '0;
  logic          ack, stall, rx_ready, tx_valid, rx_int, tx_int;
  logic [DW-1:0] rdat, tx_data;
  logic          rx_valid = 1'b0, tx_ready = 1'b0;
  logic [DW-1:0] rx_data = '0;

  always #5 clk = ~clk;

  wbstream_slave #(.DW(DW), .LGFLEN(LGFLEN)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(adr), .i_wb_data(wdat),
    .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdat),
    .i_rx_valid(rx_valid), .o_rx_ready(rx_ready), .i_rx_data(rx_data),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
    .o_rx_int(rx_int), .o_tx_int(tx_int)
  );

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // Reference state: FIFO contents as queues plus the registered outputs.
  logic [DW-1:0] tx_q[$], rx_q[$];
  int            thresh = 0;
  logic          m_ack = 1'b0, m_rx_int = 1'b0, m_tx_int = 1'b1;
  logic [DW-1:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_stall();
    return stb && !adr && (we ? (tx_q.size() == DEPTH) : (rx_q.size() == 0));
  endfunction

  task automatic bus(input logic c, input logic s, input logic w, input logic a,
                     input logic [DW-1:0] d);
    cyc = c; stb = s; we = w; adr = a; wdat = d;
  endtask

  // Check every output at the negedge, then advance the model across the posedge.
  task automatic step();
    logic acc, tx_pop, rx_push, rx_pop, tx_push, ctl;
    @(negedge clk);
    if (started) begin
      chk("stall", stall, model_stall());
      chk("ack", ack, m_ack && cyc);
      chk("rdata", rdat, m_rdata);
      chk("rx_ready", rx_ready, rx_q.size() < DEPTH);
      chk("tx_valid", tx_valid, tx_q.size() != 0);
      if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
      chk("rx_int", rx_int, m_rx_int);
      chk("tx_int", tx_int, m_tx_int);
    end
    if (rst) begin
      tx_q.delete(); rx_q.delete();
      thresh = 0; m_ack = 1'b0; m_rx_int = 1'b0; m_tx_int = 1'b1; m_rdata = '0;
    end else begin
      acc     = cyc && stb && !model_stall();
      tx_pop  = (tx_q.size() != 0) && tx_ready;
      rx_push = rx_valid && (rx_q.size() < DEPTH);
      rx_pop  = acc && !we && !adr;
      tx_push = acc && we && !adr;
      ctl     = acc && we && adr;
      m_ack    = acc;
      m_rx_int = (thresh != 0) && (rx_q.size() >= thresh);
      m_tx_int = (tx_q.size() == 0);
      if (acc && !we) m_rdata = adr ? {16'(rx_q.size()), 16'(tx_q.size())} : rx_q[0];
      if (ctl) thresh = int'(wdat[LGFLEN:0]);
      if (ctl && wdat[30]) tx_q.delete();
      else begin
        if (tx_pop) void'(tx_q.pop_front());
        if (tx_push) tx_q.push_back(wdat);
      end
      if (ctl && wdat[31]) rx_q.delete();
      else begin
        if (rx_pop) void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(rx_data);
      end
    end
    @(posedge clk);
    if (rst) started = 1'b1;
    #1;
  endtask

  initial begin
    logic [DW-1:0] words [4];

    step(); step();
    rst = 1'b0;

    // Reset state and a status read
    chk("rst_tx_int", tx_int, 1);
    chk("rst_rx_int", rx_int, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    bus(1, 1, 0, 1, '0); step();
    chk("rst_stat_ack", ack, 1);
    chk("rst_stat_data", rdat, 32'h0);
    bus(1, 0, 0, 0, '0); step();

    // Three back-to-back writes held in the TX FIFO
    tx_ready = 1'b0;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      bus(1, 1, 1, 0, words[i]); step();
      chk("wr_ack", ack, 1);
    end
    bus(1, 1, 0, 1, '0); step();
    chk("tx_fill3", rdat, 32'h0000_0003);
    bus(0, 0, 0, 0, '0);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("tx_order", tx_data, words[i]);
      step();
    end
    chk("tx_empty_valid", tx_valid, 0);
    chk("tx_int_lag", tx_int, 0);
    step();
    chk("tx_int_back", tx_int, 1);

    // Fill TX; the fifth write stalls until one word drains
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      words[i] = 32'hA0 + i;
      bus(1, 1, 1, 0, words[i]); step();
    end
    bus(1, 1, 1, 0, 32'hA4); #1;
    chk("full_stall", stall, 1);
    step();
    chk("full_no_ack", ack, 0);
    tx_ready = 1'b1; step();
    tx_ready = 1'b0; step();
    chk("fifth_ack", ack, 1);
    bus(1, 1, 0, 1, '0); step();
    chk("tx_fill4", rdat, 32'h0000_0004);
    bus(0, 0, 0, 0, '0);
    tx_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("drain_order", tx_data, words[i]);
      step();
    end
    chk("drain_last", tx_data, 32'hA4);
    step();

    // RX threshold interrupt and pipelined reads
    bus(1, 1, 1, 1, 32'd3); step();
    bus(0, 0, 0, 0, '0);
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 32'hA + i; step();
    end
    rx_valid = 1'b0;
    chk("rx_int_lag", rx_int, 0);
    step();
    chk("rx_int_rise", rx_int, 1);
    bus(1, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_ack", ack, 1);
      chk("rd_data", rdat, 32'hA + i);
    end
    #1;
    chk("rd_empty_stall", stall, 1);
    step();
    chk("rd_stall_no_ack", ack, 0);
    rx_valid = 1'b1; rx_data = 32'hD; step();
    rx_valid = 1'b0; step();
    chk("rd_late_ack", ack, 1);
    chk("rd_late_data", rdat, 32'hD);
    bus(0, 0, 0, 0, '0); step();

    // Abandoned read: pop happens, ack is suppressed
    rx_valid = 1'b1; rx_data = 32'h51; step();
    rx_data = 32'h52; step();
    rx_valid = 1'b0;
    bus(1, 1, 0, 0, '0); step();
    bus(0, 0, 0, 0, '0); #1;
    chk("abandon_ack0", ack, 0);
    step();
    chk("abandon_ack1", ack, 0);
    bus(1, 1, 0, 1, '0); step();
    chk("abandon_fill", rdat, 32'h0001_0000);
    bus(0, 0, 0, 0, '0); step();

    // Flush a full RX FIFO against a same-cycle stream word
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 32'h60 + i; step();
    end
    chk("rx_full_ready", rx_ready, 0);
    rx_data = 32'hEE;
    bus(1, 1, 1, 1, 32'h8000_0000); step();
    chk("flush_ready", rx_ready, 1);
    rx_valid = 1'b0;
    bus(1, 1, 0, 1, '0); step();
    chk("flush_fill", rdat, 32'h0);
    bus(0, 0, 0, 0, '0); step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc = ($urandom_range(0, 9) != 0);
      stb = cyc ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
      we  = 1'($urandom_range(0, 1));
      adr = ($urandom_range(0, 7) == 0);
      if (adr && we)
        wdat = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), 27'b0,
                3'($urandom_range(0, 4))};
      else
        wdat = $urandom;
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = $urandom;
      tx_ready = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 299) == 0);
      step();
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
